// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS front end.
//   - Opcode constants decoded by the control unit from op_code.
//   - NOP_INSTR bubble encoding and the default reset PC.
//   - Fetch FSM state type.
//   - j_target(): J-type jump target from the IF/ID PC+4 and instruction.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000; // sll $0,$0,0
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // {pc4[31:28], instr[25:0], 2'b00}, written with masks so every
    // argument bit is consumed.
    function automatic logic [31:0] j_target(input logic [31:0] pc4,
                                             input logic [31:0] instr);
        return (pc4 & 32'hF000_0000) | ((instr << 2) & 32'h0FFF_FFFC);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: combinational next-PC priority mux.
//   Priority: branch_taken > jump > sequential (pc + 4, wraps mod 2^32).
//   Jump only counts when IF/ID holds a real instruction and is not stalled;
//   a taken branch is always honoured.
// Ports:
//   pc, if_id_valid, if_id_instr, if_id_pc4 : current PC and IF/ID contents
//   stall, jump, branch_taken, branch_target : redirect controls
//   next_pc  : selected next PC (word aligned)
//   redirect : 1 when next_pc is a jump/branch target
module next_pc_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        if_id_valid,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] if_id_pc4,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        redirect
);

    logic jump_ok;
    assign jump_ok = jump & if_id_valid & ~stall;

    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        if (branch_taken) begin
            next_pc  = branch_target & 32'hFFFF_FFFC;
            redirect = 1'b1;
        end else if (jump_ok) begin
            next_pc  = j_target(if_id_pc4, if_id_instr);
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: MIPS IF stage. Owns the PC, runs the imem request
// handshake (one outstanding request max), loads IF/ID and applies stall,
// jump and branch redirects.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   imem_req/imem_addr    : fetch request, address held until imem_ready
//   imem_rdata/imem_ready : returned instruction / request completion
//   stall                 : hold IF/ID (returned data parks in the skid)
//   jump                  : IF/ID instruction is a J
//   branch_taken/target   : EX-stage BEQ resolution
//   if_id_valid/instr/pc4 : IF/ID pipeline register
//   op_code               : if_id_instr[31:26]
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  op_code
);
    import mips_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc4;
    logic         redirect_pending;
    logic [31:0]  pend_target;
    logic [31:0]  next_pc;
    logic         redirect;

    next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .stall         (stall),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

    assign imem_addr = pc;
    assign op_code   = if_id_instr[31:26];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            imem_req         <= 1'b0;
            pc               <= RESET_PC;
            if_id_valid      <= 1'b0;
            if_id_instr      <= NOP_INSTR;
            if_id_pc4        <= 32'd0;
            skid_instr       <= NOP_INSTR;
            skid_pc4         <= 32'd0;
            redirect_pending <= 1'b0;
            pend_target      <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                    if (redirect)
                        pc <= next_pc;
                end

                FETCH: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        skid_instr  <= NOP_INSTR;
                        if (imem_ready) begin
                            // in-flight data is dropped, next request to target
                            pc               <= next_pc;
                            redirect_pending <= 1'b0;
                        end else begin
                            // address must stay put until the request completes
                            redirect_pending <= 1'b1;
                            pend_target      <= next_pc;
                        end
                    end else if (redirect_pending) begin
                        if (!stall) begin
                            if_id_valid <= 1'b0;
                            if_id_instr <= NOP_INSTR;
                        end
                        if (imem_ready) begin
                            pc               <= pend_target;
                            redirect_pending <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        pc <= next_pc;
                        if (stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc4   <= next_pc;
                            state      <= HOLD;
                            imem_req   <= 1'b0;
                        end else begin
                            if_id_valid <= 1'b1;
                            if_id_instr <= imem_rdata;
                            if_id_pc4   <= next_pc;
                        end
                    end else if (!stall) begin
                        // IF/ID consumed with nothing to replace it: bubble
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= NOP_INSTR;
                        skid_instr  <= NOP_INSTR;
                        pc          <= next_pc;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end else if (!stall) begin
                        if_id_valid <= 1'b1;
                        if_id_instr <= skid_instr;
                        if_id_pc4   <= skid_pc4;
                        skid_instr  <= NOP_INSTR;
                        state       <= FETCH;
                        imem_req    <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        jump;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  op_code;

    int n_chk = 0;
    int n_err = 0;

    instr_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .op_code       (op_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: a J at 0xC, an LW at 0x108, ADDI elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_000C: return 32'h0800_0010;
            32'h0000_0108: return 32'h8C22_0004;
            default:       return {6'b001000, a[25:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        imem_ready    = 1'b1;
        stall         = 1'b0;
        jump          = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;

        // reset values
        #1;
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr,          32'h0);
        chk("rst_pc4",   if_id_pc4,            32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // sequential fetch, ready tied high
        step();
        chk("seq_req1",   {31'd0, imem_req},    32'd1);
        chk("seq_addr0",  imem_addr,            32'h0);
        chk("seq_valid0", {31'd0, if_id_valid}, 32'd0);
        step();
        chk("seq_addr4",  imem_addr,            32'h4);
        chk("seq_valid1", {31'd0, if_id_valid}, 32'd1);
        chk("seq_pc4_4",  if_id_pc4,            32'h4);
        step();
        chk("seq_addr8",  imem_addr,            32'h8);
        chk("seq_pc4_8",  if_id_pc4,            32'h8);
        step();
        chk("seq_pc4_c",  if_id_pc4,            32'hC);
        step();
        chk("j_pc4",      if_id_pc4,            32'h10);
        chk("j_instr",    if_id_instr,          32'h0800_0010);
        chk("j_opcode",   {26'd0, op_code},     {26'd0, 6'b000010});

        // jump from IF/ID
        jump = 1'b1;
        step();
        jump = 1'b0;
        chk("j_addr",     imem_addr,            32'h40);
        chk("j_flush_v",  {31'd0, if_id_valid}, 32'd0);
        chk("j_flush_i",  if_id_instr,          32'h0);
        step();
        chk("j_tgt_v",    {31'd0, if_id_valid}, 32'd1);
        chk("j_tgt_pc4",  if_id_pc4,            32'h44);
        chk("j_tgt_i",    if_id_instr,          32'h2000_0040);

        // branch to 0x20, then let that request wait
        branch_taken = 1'b1; branch_target = 32'h20;
        step();
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        chk("b20_addr",   imem_addr,            32'h20);
        branch_taken = 1'b1; branch_target = 32'h103;
        step();
        branch_taken = 1'b0;
        chk("bp_addr_hold", imem_addr,          32'h20);
        chk("bp_valid0",  {31'd0, if_id_valid}, 32'd0);
        step();
        chk("bp_addr_hold2", imem_addr,         32'h20);
        chk("bp_valid1",  {31'd0, if_id_valid}, 32'd0);
        step();
        chk("bp_valid2",  {31'd0, if_id_valid}, 32'd0);
        imem_ready = 1'b1;
        step();
        chk("bp_addr_tgt", imem_addr,           32'h100);
        chk("bp_valid3",  {31'd0, if_id_valid}, 32'd0);
        chk("bp_req",     {31'd0, imem_req},    32'd1);
        step();
        chk("bp_first_v", {31'd0, if_id_valid}, 32'd1);
        chk("bp_first_pc4", if_id_pc4,          32'h104);
        step();
        chk("st_pre_pc4", if_id_pc4,            32'h108);
        chk("st_pre_addr", imem_addr,           32'h108);

        // stall while the LW at 0x108 returns
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_req",   {31'd0, imem_req},  32'd0);
            chk("st_pc4",   if_id_pc4,          32'h108);
            chk("st_instr", if_id_instr,        32'h2000_0104);
        end
        stall = 1'b0;
        step();
        chk("st_rel_instr", if_id_instr,        32'h8C22_0004);
        chk("st_rel_op",  {26'd0, op_code},     {26'd0, 6'b100011});
        chk("st_rel_pc4", if_id_pc4,            32'h10C);
        chk("st_rel_addr", imem_addr,           32'h10C);
        chk("st_rel_req", {31'd0, imem_req},    32'd1);
        step();
        chk("st_next_pc4", if_id_pc4,           32'h110);

        // jump and branch together: branch wins
        jump = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        chk("jb_addr",    imem_addr,            32'h200);
        chk("jb_valid",   {31'd0, if_id_valid}, 32'd0);

        // PC wrap; low target bits are ignored
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        step();
        branch_taken = 1'b0;
        chk("wr_addr",    imem_addr,            32'hFFFF_FFFC);
        step();
        chk("wr_addr0",   imem_addr,            32'h0);
        chk("wr_pc4",     if_id_pc4,            32'h0);
        chk("wr_instr",   if_id_instr,          32'h23FF_FFFC);

        // reset while a request to 0x44 is outstanding
        branch_taken = 1'b1; branch_target = 32'h44;
        step();
        branch_taken = 1'b0;
        imem_ready   = 1'b0;
        step();
        chk("mr_addr",    imem_addr,            32'h44);
        chk("mr_req",     {31'd0, imem_req},    32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_rst_req",   {31'd0, imem_req},    32'd0);
        chk("mr_rst_addr",  imem_addr,            32'h0);
        chk("mr_rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("mr_rst_instr", if_id_instr,          32'h0);
        chk("mr_rst_pc4",   if_id_pc4,            32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        imem_ready = 1'b1;
        step();
        chk("mr_first_addr", imem_addr,         32'h0);
        chk("mr_first_req", {31'd0, imem_req},  32'd1);
        step();
        chk("mr_first_pc4", if_id_pc4,          32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
